// File: rtl/midi_rx_fifo.sv
// midi_rx_fifo
//   MIDI (31250 baud, 8N1) serial receiver feeding a small pop-on-read FIFO.
//   Bytes are decoded from the raw line, buffered, and exposed to the
//   cartridge register decode together with status flags and an active-high
//   interrupt request.
//
// Ports
//   clock      system clock, rising-edge active
//   reset      asynchronous, active-high reset
//   rxd_in     raw serial line (asynchronous, idle high)
//   rd_en      one-cycle pop strobe
//   clr_err    one-cycle strobe clearing overrun / frame_err
//   irq_en     interrupt enable
//   rx_data    head-of-FIFO byte, 0x00 when empty
//   rx_valid   FIFO not empty
//   rx_full    FIFO holds DEPTH entries
//   rx_count   number of entries held
//   overrun    sticky: byte dropped because the FIFO was full
//   frame_err  sticky: stop bit sampled low
//   irq        irq_en & (rx_valid | overrun | frame_err)

module midi_rx_fifo #(
    parameter int BIT_CYCLES = 32,
    parameter int DEPTH      = 8,
    parameter int PTR_W      = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rxd_in,
    input  logic             rd_en,
    input  logic             clr_err,
    input  logic             irq_en,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_full,
    output logic [PTR_W:0]   rx_count,
    output logic             overrun,
    output logic             frame_err,
    output logic             irq
);

    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_CYCLES - 1);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Line synchroniser; both flops reset to the idle (high) level so a
    // reset never looks like a start bit.
    // ------------------------------------------------------------------
    logic sync1;
    logic rxs;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd_in;
            rxs   <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             cnt_clr;
    logic             shift;
    logic             push;
    logic             ferr_set;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_clr ? '0 : cnt + 1'b1;
            // bit index is re-armed for the whole start-bit interval so
            // DATA always begins at bit 0
            if (state == S_START)
                bit_idx <= '0;
            else if (shift)
                bit_idx <= bit_idx + 1'b1;
            // LSB arrives first, so shift in from the top
            if (shift)
                shreg <= {rxs, shreg[7:1]};
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift     = 1'b0;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (!rxs)
                    state_nxt = S_START;
            end
            S_START: begin
                // mid-bit re-check rejects short glitches
                if (cnt == HALF_M1) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_clr = 1'b1;
                    shift   = 1'b1;
                    if (bit_idx == 3'd7)
                        state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_clr = 1'b1;
                    if (rxs) begin
                        push      = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // a held-low line must go high before another start bit
                cnt_clr = 1'b1;
                if (rxs)
                    state_nxt = S_IDLE;
            end
            default: begin
                cnt_clr   = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             pop_ok;
    logic             push_ok;

    assign rx_full  = (count == DEPTH_C);
    assign rx_valid = (count != '0);
    assign pop_ok   = rd_en && rx_valid;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push_ok  = push && (!rx_full || pop_ok);

    always_ff @(posedge clock) begin
        if (push_ok)
            mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // sticky flags: a new event on the same edge as clr_err wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push && rx_full && !pop_ok)
                overrun <= 1'b1;
            else if (clr_err)
                overrun <= 1'b0;
            if (ferr_set)
                frame_err <= 1'b1;
            else if (clr_err)
                frame_err <= 1'b0;
        end
    end

    assign rx_count = count;
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
    assign irq      = irq_en && (rx_valid || overrun || frame_err);

endmodule

// File: tb/tb_midi_rx_fifo.sv
module tb_midi_rx_fifo;

    localparam int BIT_CYCLES = 32;
    localparam int DEPTH      = 8;
    localparam int PTR_W      = 3;

    logic             clock;
    logic             reset;
    logic             rxd_in;
    logic             rd_en;
    logic             clr_err;
    logic             irq_en;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_full;
    logic [PTR_W:0]   rx_count;
    logic             overrun;
    logic             frame_err;
    logic             irq;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] sb[$];

    midi_rx_fifo #(
        .BIT_CYCLES(BIT_CYCLES),
        .DEPTH     (DEPTH),
        .PTR_W     (PTR_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rxd_in   (rxd_in),
        .rd_en    (rd_en),
        .clr_err  (clr_err),
        .irq_en   (irq_en),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_full  (rx_full),
        .rx_count (rx_count),
        .overrun  (overrun),
        .frame_err(frame_err),
        .irq      (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // advance n cycles, landing 1 time unit after the last rising edge
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // drive one frame; the line is left at the stop-bit level
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic ok);
        if (ok)
            sb.push_back(b);
        rxd_in = 1'b0;
        step(BIT_CYCLES);
        for (int i = 0; i < 8; i++) begin
            rxd_in = b[i];
            step(BIT_CYCLES);
        end
        rxd_in = stop;
        step(BIT_CYCLES);
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        e = (sb.size() != 0) ? 32'(sb.pop_front()) : 32'hDEAD;
        check({tag, "_valid"}, 32'(rx_valid), 32'd1);
        check(tag, 32'(rx_data), e);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] e;
        reset   = 1'b1;
        rxd_in  = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        irq_en  = 1'b1;

        // reset state
        step(3);
        check("rst_valid",  32'(rx_valid),  32'd0);
        check("rst_data",   32'(rx_data),   32'd0);
        check("rst_count",  32'(rx_count),  32'd0);
        check("rst_ovr",    32'(overrun),   32'd0);
        check("rst_ferr",   32'(frame_err), 32'd0);
        check("rst_irq",    32'(irq),       32'd0);
        reset = 1'b0;
        step(5);

        // single byte with latency measurement from the start-bit edge
        n = 0;
        fork
            send_frame(8'h90, 1'b1, 1'b1);
            begin
                while (!rx_valid && n < 400) begin
                    step(1);
                    n++;
                end
            end
        join
        check("lat_in_range", 32'(n >= 305 && n <= 307), 32'd1);
        check("single_count", 32'(rx_count), 32'd1);
        check("single_irq",   32'(irq),      32'd1);
        irq_en = 1'b0;
        #1;
        check("irq_masked",   32'(irq),      32'd0);
        irq_en = 1'b1;
        pop_check("single_data");
        check("single_empty", 32'(rx_valid), 32'd0);
        check("single_zero",  32'(rx_data),  32'd0);
        check("single_irq0",  32'(irq),      32'd0);
        // pop while empty is ignored
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check("empty_pop_cnt", 32'(rx_count), 32'd0);

        // false start glitch
        rxd_in = 1'b0;
        step(8);
        rxd_in = 1'b1;
        step(100);
        check("glitch_valid", 32'(rx_valid),  32'd0);
        check("glitch_count", 32'(rx_count),  32'd0);
        check("glitch_ferr",  32'(frame_err), 32'd0);
        check("glitch_ovr",   32'(overrun),   32'd0);

        // fill and overrun
        for (int i = 1; i <= 9; i++)
            send_frame(8'(i), 1'b1, i <= DEPTH);
        check("fill_full",  32'(rx_full),  32'd1);
        check("fill_count", 32'(rx_count), 32'd8);
        check("fill_ovr",   32'(overrun),  32'd1);
        for (int i = 0; i < DEPTH; i++)
            pop_check("fill_drain");
        check("fill_empty", 32'(rx_valid), 32'd0);
        check("ovr_kept",   32'(overrun),  32'd1);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("ovr_clr",    32'(overrun),  32'd0);

        // push and pop on the same edge while full
        for (int i = 1; i <= DEPTH; i++)
            send_frame(8'(i), 1'b1, 1'b1);
        fork
            send_frame(8'h7F, 1'b1, 1'b1);
            begin
                step(306);
                e = (sb.size() != 0) ? 32'(sb.pop_front()) : 32'hDEAD;
                check("simul_head", 32'(rx_data), e);
                rd_en = 1'b1;
                step(1);
                rd_en = 1'b0;
            end
        join
        check("simul_ovr",   32'(overrun),  32'd0);
        check("simul_count", 32'(rx_count), 32'd8);
        for (int i = 0; i < DEPTH; i++)
            pop_check("simul_drain");
        check("simul_empty", 32'(rx_valid), 32'd0);

        // framing error followed by a long break
        send_frame(8'h55, 1'b0, 1'b0);
        step(1000);
        rxd_in = 1'b1;
        step(40);
        send_frame(8'h3C, 1'b1, 1'b1);
        check("brk_ferr",  32'(frame_err), 32'd1);
        check("brk_count", 32'(rx_count),  32'd1);
        pop_check("brk_data");
        check("brk_empty", 32'(rx_valid),  32'd0);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("ferr_clr",  32'(frame_err), 32'd0);
        // clear coinciding with a new frame error
        fork
            send_frame(8'h55, 1'b0, 1'b0);
            begin
                step(306);
                clr_err = 1'b1;
                step(1);
                clr_err = 1'b0;
            end
        join
        check("ferr_setwin", 32'(frame_err), 32'd1);
        check("ferr_count",  32'(rx_count),  32'd0);
        rxd_in = 1'b1;
        step(40);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;

        // reset in the middle of a frame
        send_frame(8'h11, 1'b1, 1'b1);
        check("pre_rst_valid", 32'(rx_valid), 32'd1);
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                step(170);
                reset = 1'b1;
                #2;
                check("mid_rst_valid", 32'(rx_valid), 32'd0);
                check("mid_rst_count", 32'(rx_count), 32'd0);
                check("mid_rst_data",  32'(rx_data),  32'd0);
                check("mid_rst_irq",   32'(irq),      32'd0);
            end
        join
        step(2);
        reset = 1'b0;
        sb.delete();
        step(5);
        send_frame(8'hF8, 1'b1, 1'b1);
        check("post_rst_count", 32'(rx_count), 32'd1);
        pop_check("post_rst_data");
        check("post_rst_empty", 32'(rx_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
